// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Samples an asynchronous PWM input, measures high time and
//               period of each cycle and recovers the 4-bit level that
//               produced it. Also flags out-of-tolerance periods and inputs
//               stuck high or low.
//               Optional build macro PWM_CAPTURE_FILTER_EN adds a 3-sample
//               glitch filter after the synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture #(
    parameter int PERIOD_CYCLES  = 256,
    parameter int PERIOD_TOL     = 4,
    parameter int TIMEOUT_CYCLES = 512,
    parameter int CNT_W          = 10
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_pwm,
    output logic [3:0] o_lvl,
    output logic       o_valid,
    output logic       o_per_err,
    output logic       o_stuck
);

    localparam logic [CNT_W-1:0] c_cnt_max    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_per_min    = CNT_W'(PERIOD_CYCLES - PERIOD_TOL);
    localparam logic [CNT_W-1:0] c_per_max    = CNT_W'(PERIOD_CYCLES + PERIOD_TOL);
    localparam logic [CNT_W-1:0] c_timeout_m1 = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } state_t;

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == c_cnt_max) ? v : v + CNT_W'(1);
    endfunction

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic             w_sig;
    logic             w_rise;
    logic             w_fall;
    logic             w_edge;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] w_high_nxt;
    logic [CNT_W-1:0] w_per_nxt;
    logic [CNT_W-1:0] w_idle_nxt;
    logic [3:0]       w_lvl_nxt;
    logic             w_valid_nxt;
    logic             w_per_err_nxt;
    logic             w_stuck_nxt;

    logic [CNT_W-1:0] w_rnd;
    logic [CNT_W-1:0] w_q;
    logic [CNT_W-1:0] w_qm1;
    logic [3:0]       w_lvl_dec;
    logic             w_per_bad;

    // Two-flop synchronizer for the asynchronous PWM pin.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pwm;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic r_hist0;
    logic r_hist1;
    logic r_filt;
    logic w_agree;

    // The filtered level only follows the input once three consecutive
    // synchronized samples agree, so 1-2 cycle pulses never reach the edge
    // detector. Both edges are delayed equally, leaving H and P intact.
    assign w_agree = (r_sync2 == r_hist0) && (r_sync2 == r_hist1);
    assign w_sig   = w_agree ? r_sync2 : r_filt;

    // Sample history and held filter output.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_hist0 <= 1'b0;
            r_hist1 <= 1'b0;
            r_filt  <= 1'b0;
        end else begin
            r_hist0 <= r_sync2;
            r_hist1 <= r_hist0;
            r_filt  <= w_sig;
        end
    end
`else
    assign w_sig = r_sync2;
`endif

    // Registered copy of the conditioned input for edge detection.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_sig;
        end
    end

    assign w_rise = w_sig & ~r_prev;
    assign w_fall = ~w_sig & r_prev;
    assign w_edge = w_rise | w_fall;

    // Level decode: round H to the nearest multiple of 16, then remove the
    // +1 offset the generator adds to every non-zero level.
    assign w_rnd     = r_high_cnt + CNT_W'(8);
    assign w_q       = w_rnd >> 4;
    assign w_qm1     = w_q - CNT_W'(1);
    assign w_lvl_dec = (w_q == '0)            ? 4'd0  :
                       (w_qm1 > CNT_W'(15))   ? 4'd15 : w_qm1[3:0];
    assign w_per_bad = (r_per_cnt < c_per_min) || (r_per_cnt > c_per_max);

    // Next-state, counter and output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_high_nxt    = r_high_cnt;
        w_per_nxt     = r_per_cnt;
        w_idle_nxt    = w_edge ? '0 : sat_inc(r_idle_cnt);
        w_lvl_nxt     = o_lvl;
        w_valid_nxt   = 1'b0;
        w_per_err_nxt = o_per_err;
        w_stuck_nxt   = w_edge ? 1'b0 : o_stuck;

        case (r_state)
            WAIT_RISE: begin
                // First rise only arms measurement; nothing is reported.
                if (w_rise) begin
                    w_state_nxt = MEAS_HIGH;
                    w_high_nxt  = CNT_W'(1);
                    w_per_nxt   = CNT_W'(1);
                end
            end
            MEAS_HIGH: begin
                w_per_nxt = sat_inc(r_per_cnt);
                if (w_fall) begin
                    w_state_nxt = MEAS_LOW;
                end else begin
                    w_high_nxt = sat_inc(r_high_cnt);
                end
            end
            MEAS_LOW: begin
                if (w_rise) begin
                    w_lvl_nxt     = w_lvl_dec;
                    w_per_err_nxt = w_per_bad;
                    w_valid_nxt   = 1'b1;
                    w_high_nxt    = CNT_W'(1);
                    w_per_nxt     = CNT_W'(1);
                    w_state_nxt   = MEAS_HIGH;
                end else begin
                    w_per_nxt = sat_inc(r_per_cnt);
                end
            end
            default: begin
                w_state_nxt = WAIT_RISE;
            end
        endcase

        // Timeout fires once: the idle counter moves past the threshold and
        // saturates. An edge in the same cycle takes priority.
        if (!w_edge && (r_idle_cnt == c_timeout_m1)) begin
            w_stuck_nxt   = 1'b1;
            w_lvl_nxt     = w_sig ? 4'd15 : 4'd0;
            w_valid_nxt   = 1'b1;
            w_per_err_nxt = 1'b0;
            w_state_nxt   = WAIT_RISE;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state    <= WAIT_RISE;
            r_high_cnt <= '0;
            r_per_cnt  <= '0;
            r_idle_cnt <= '0;
            o_lvl      <= 4'd0;
            o_valid    <= 1'b0;
            o_per_err  <= 1'b0;
            o_stuck    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_high_cnt <= w_high_nxt;
            r_per_cnt  <= w_per_nxt;
            r_idle_cnt <= w_idle_nxt;
            o_lvl      <= w_lvl_nxt;
            o_valid    <= w_valid_nxt;
            o_per_err  <= w_per_err_nxt;
            o_stuck    <= w_stuck_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pwm_capture
// Description : Directed, table-driven bench for pwm_capture. Honours the
//               PWM_CAPTURE_FILTER_EN build macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_pwm;
    logic [3:0] o_lvl;
    logic       o_valid;
    logic       o_per_err;
    logic       o_stuck;

    always #5 clk = ~clk;

    pwm_capture dut (
        .clk       (clk),
        .i_rst     (i_rst),
        .i_pwm     (i_pwm),
        .o_lvl     (o_lvl),
        .o_valid   (o_valid),
        .o_per_err (o_per_err),
        .o_stuck   (o_stuck)
    );

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [3:0] lvl;
        logic       err;
        logic       stk;
        int         cyc;
    } cap_t;

    typedef struct {
        int h;
        int p;
        int lvl;
        int err;
    } vec_t;

    cap_t cap_q[$];
    cap_t cap_tmp;
    vec_t vecs[$];
    int   rise_cyc[$];

    // Cycle count = number of rising clock edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every o_valid pulse with the outputs that accompany it.
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            cap_tmp.lvl = o_lvl;
            cap_tmp.err = o_per_err;
            cap_tmp.stk = o_stuck;
            cap_tmp.cyc = cyc;
            cap_q.push_back(cap_tmp);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        i_pwm = 1'b0;
        i_rst = 1'b1;
        tick(3);
        i_rst = 1'b0;
    endtask

    task automatic drive_period(input int h, input int p);
        i_pwm = 1'b1;
        tick(h);
        i_pwm = 1'b0;
        tick(p - h);
    endtask

    function automatic void add(input int h, input int p, input int lvl, input int err);
        vec_t v;
        v.h   = h;
        v.p   = p;
        v.lvl = lvl;
        v.err = err;
        vecs.push_back(v);
    endfunction

    initial begin
        int final_rise;
        int exp_cyc;
        int r1;

        // ---------------- vector table ----------------
        add(96, 256, 5, 0);
        add(96, 256, 5, 0);
        add(96, 256, 5, 0);
`ifndef PWM_CAPTURE_FILTER_EN
        add(2, 256, 0, 0);
        add(2, 256, 0, 0);
`endif
        for (int l = 1; l <= 14; l++) add(16 * (l + 1), 256, l, 0);
        add(89, 256, 5, 0);
        add(103, 256, 5, 0);
        add(104, 256, 6, 0);
        add(64, 300, 3, 1);
        add(64, 258, 3, 0);
        add(96, 251, 5, 1);
        add(96, 252, 5, 0);
        add(96, 260, 5, 0);
        add(96, 261, 5, 1);

        // ---------------- reset state ----------------
        do_reset();
        @(negedge clk);
        check("rst o_lvl", 32'(o_lvl), 0);
        check("rst o_valid", 32'(o_valid), 0);
        check("rst o_per_err", 32'(o_per_err), 0);
        check("rst o_stuck", 32'(o_stuck), 0);

        // ---------------- table run ----------------
        tick(10);
        cap_q.delete();
        foreach (vecs[i]) begin
            rise_cyc.push_back(cyc);
            drive_period(vecs[i].h, vecs[i].p);
        end
        final_rise = cyc;
        i_pwm = 1'b1;
        tick(LAT + 3);
        check("table valid count", 32'(cap_q.size()), 32'(vecs.size()));
        for (int i = 0; i < vecs.size() && i < cap_q.size(); i++) begin
            exp_cyc = ((i + 1 < vecs.size()) ? rise_cyc[i + 1] : final_rise) + LAT;
            check($sformatf("vec%0d H=%0d P=%0d lvl", i, vecs[i].h, vecs[i].p), 32'(cap_q[i].lvl), 32'(vecs[i].lvl));
            check($sformatf("vec%0d per_err", i), 32'(cap_q[i].err), 32'(vecs[i].err));
            check($sformatf("vec%0d stuck", i), 32'(cap_q[i].stk), 0);
            check($sformatf("vec%0d valid cycle", i), 32'(cap_q[i].cyc), 32'(exp_cyc));
        end

        // ---------------- stuck high ----------------
        do_reset();
        tick(10);
        cap_q.delete();
        drive_period(96, 256);
        r1 = cyc;
        i_pwm = 1'b1;
        tick(600);
        @(negedge clk);
        check("stuck o_stuck set", 32'(o_stuck), 1);
        check("stuck valid count", 32'(cap_q.size()), 2);
        if (cap_q.size() == 2) begin
            check("stuck pre lvl", 32'(cap_q[0].lvl), 5);
            check("stuck pre cycle", 32'(cap_q[0].cyc), 32'(r1 + LAT));
            check("stuck lvl", 32'(cap_q[1].lvl), 15);
            check("stuck flag at valid", 32'(cap_q[1].stk), 1);
            check("stuck per_err", 32'(cap_q[1].err), 0);
            check("stuck valid cycle", 32'(cap_q[1].cyc), 32'(r1 + LAT + 512));
        end
        i_pwm = 1'b0;
        tick(LAT - 1);
        @(negedge clk);
        check("stuck held before fall seen", 32'(o_stuck), 1);
        tick(1);
        @(negedge clk);
        check("stuck cleared by fall", 32'(o_stuck), 0);
        check("no valid on fall from stuck", 32'(cap_q.size()), 2);

        // ---------------- reset mid MEAS_LOW ----------------
        do_reset();
        tick(10);
        drive_period(96, 256);
        i_pwm = 1'b1;
        tick(96);
        i_pwm = 1'b0;
        tick(50);
        @(negedge clk);
        check("pre-reset o_lvl", 32'(o_lvl), 5);
        i_rst = 1'b1;
        tick(1);
        i_rst = 1'b0;
        @(negedge clk);
        check("midrst o_lvl", 32'(o_lvl), 0);
        check("midrst o_valid", 32'(o_valid), 0);
        check("midrst o_per_err", 32'(o_per_err), 0);
        check("midrst o_stuck", 32'(o_stuck), 0);
        cap_q.delete();
        tick(150);
        drive_period(96, 256);
        check("midrst no valid at first rise", 32'(cap_q.size()), 0);
        i_pwm = 1'b1;
        tick(LAT + 2);
        check("midrst valid at second rise", 32'(cap_q.size()), 1);
        if (cap_q.size() == 1) check("midrst lvl", 32'(cap_q[0].lvl), 5);

        // ---------------- 1-cycle low glitch in high phase ----------------
        do_reset();
        tick(10);
        cap_q.delete();
        i_pwm = 1'b1;
        tick(40);
        i_pwm = 1'b0;
        tick(1);
        i_pwm = 1'b1;
        tick(55);
        i_pwm = 1'b0;
        tick(160);
        i_pwm = 1'b1;
        tick(LAT + 3);
`ifdef PWM_CAPTURE_FILTER_EN
        check("glitch valid count", 32'(cap_q.size()), 1);
        if (cap_q.size() == 1) begin
            check("glitch lvl", 32'(cap_q[0].lvl), 5);
            check("glitch per_err", 32'(cap_q[0].err), 0);
        end
`else
        check("glitch valid count", 32'(cap_q.size()), 2);
        if (cap_q.size() == 2) begin
            check("glitch short lvl", 32'(cap_q[0].lvl), 2);
            check("glitch short per_err", 32'(cap_q[0].err), 1);
            check("glitch rest lvl", 32'(cap_q[1].lvl), 2);
            check("glitch rest per_err", 32'(cap_q[1].err), 1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
